// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM states, owner index, grant encodings.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    ABORT = 2'd3
  } arb_state_e;

  typedef logic owner_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;

  function automatic logic [1:0] grant_of(input owner_t owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts owner cycles with strobe pending and no ack, and flags expiry
// on the cycle the count reaches TIMEOUT_CYCLES-1. An ack in that same cycle suppresses expiry.
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_stb,
  input  logic i_ack,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;

  assign o_expire = i_active & i_stb & ~i_ack & (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Stall counter: cleared outside ownership, on ack and on expiry; holds while stb is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_active || i_ack || o_expire) begin
      r_cnt <= '0;
    end else if (i_stb) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter, round-robin, grant held for the owner's cyc.
// Optional stall watchdog with ABORT state when WB_ARB_TIMEOUT_EN is defined.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RESET_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_ack_i,
  output logic [1:0]            grant_o
);

  localparam owner_t PRIO_INIT = owner_t'(RESET_PRIO != 0);

  arb_state_e r_state;
  owner_t     r_owner;
  owner_t     r_prio;
  logic [1:0] r_grant;

  logic w_own0, w_own1, w_own, w_sel_cyc;

  assign w_own0    = (r_state == OWN0);
  assign w_own1    = (r_state == OWN1);
  assign w_own     = w_own0 | w_own1;
  assign w_sel_cyc = w_own1 ? m1_cyc_i : m0_cyc_i;

  // Slave side follows the owner combinationally; everything is quiet outside ownership.
  assign s_cyc_o  = w_own & w_sel_cyc;
  assign s_stb_o  = w_own & (w_own1 ? m1_stb_i : m0_stb_i);
  assign s_we_o   = w_own & (w_own1 ? m1_we_i : m0_we_i);
  assign s_addr_o = w_own ? (w_own1 ? m1_addr_i : m0_addr_i) : '0;
  assign s_data_o = w_own ? (w_own1 ? m1_data_i : m0_data_i) : '0;

  assign m0_ack_o  = w_own0 & s_ack_i;
  assign m1_ack_o  = w_own1 & s_ack_i;
  assign m0_data_o = w_own ? s_data_i : '0;
  assign m1_data_o = w_own ? s_data_i : '0;
  assign grant_o   = r_grant;

`ifdef WB_ARB_TIMEOUT_EN
  logic w_expire;

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_active (w_own),
    .i_stb    (s_stb_o),
    .i_ack    (s_ack_i),
    .o_expire (w_expire)
  );

  assign m0_err_o = (r_state == ABORT) & ~r_owner;
  assign m1_err_o = (r_state == ABORT) &  r_owner;
`else
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

  // Arbitration FSM: registered grant, pointer moves to the other master on every release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= PRIO_INIT;
      r_prio  <= PRIO_INIT;
      r_grant <= GRANT_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            r_owner <= r_prio;
            r_state <= r_prio ? OWN1 : OWN0;
            r_grant <= grant_of(r_prio);
          end else if (m0_cyc_i) begin
            r_owner <= 1'b0;
            r_state <= OWN0;
            r_grant <= grant_of(1'b0);
          end else if (m1_cyc_i) begin
            r_owner <= 1'b1;
            r_state <= OWN1;
            r_grant <= grant_of(1'b1);
          end else begin
            r_state <= IDLE;
          end
        end
        OWN0, OWN1: begin
          if (!w_sel_cyc) begin
            r_state <= IDLE;
            r_prio  <= ~r_owner;
            r_grant <= GRANT_NONE;
`ifdef WB_ARB_TIMEOUT_EN
          end else if (w_expire) begin
            r_state <= ABORT;
            r_grant <= GRANT_NONE;
`endif
          end else begin
            r_state <= r_state;
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        ABORT: begin
          r_state <= IDLE;
          r_prio  <= ~r_owner;
        end
`endif
        default: begin
          r_state <= IDLE;
          r_grant <= GRANT_NONE;
        end
      endcase
    end
  end

endmodule
